// File: rtl/ucode_seq.sv
// Microcode address sequencer: registered ROM address, next-address selection
// from the sequencing field, 2-deep return stack and start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; rom_addr parked
// RUN   | stepping microcode words; busy asserted
module ucode_seq #(
  parameter int AW = 9,
  parameter int SD = 2
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          start,
  input  logic [AW-1:0] entry_addr,
  input  logic          hold,
  input  logic [2:0]    u_seq,
  input  logic [AW-1:0] u_jaddr,
  input  logic          br_bit1,
  input  logic          br_bit0,
  output logic [AW-1:0] rom_addr,
  output logic          ucode_busy,
  output logic          ucode_done,
  output logic          stk_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] PTR_FULL = 2'(SD);

  state_t        state_q, state_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [AW-1:0] stk_q [SD];
  logic [AW-1:0] stk_d [SD];
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] stk_top;

  assign addr_inc = rom_addr_q + AW'(1);
  // pointer is 1 or 2 whenever a pop is legal, so the top sits at ptr-1
  assign stk_top  = (ptr_q == PTR_FULL) ? stk_q[1] : stk_q[0];

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    done_d     = 1'b0;
    err_d      = err_q;
    ptr_d      = ptr_q;
    stk_d      = stk_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rom_addr_d = entry_addr;
          err_d      = 1'b0;
          ptr_d      = 2'd0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          case (u_seq)
            3'b000, 3'b110, 3'b111: rom_addr_d = addr_inc;
            3'b001: rom_addr_d = u_jaddr;
            3'b010: rom_addr_d = {u_jaddr[AW-1:2], br_bit1, br_bit0};
            3'b011: begin
              if (ptr_q != PTR_FULL) begin
                stk_d[ptr_q[0]] = addr_inc;
                ptr_d           = ptr_q + 2'd1;
              end else begin
                err_d = 1'b1;
              end
              rom_addr_d = u_jaddr;
            end
            3'b100: begin
              if (ptr_q != 2'd0) begin
                rom_addr_d = stk_top;
                ptr_d      = ptr_q - 2'd1;
              end else begin
                err_d      = 1'b1;
                rom_addr_d = addr_inc;
              end
            end
            3'b101: begin
              done_d = 1'b1;
              ptr_d  = 2'd0;
              if (start) begin
                rom_addr_d = entry_addr;
                err_d      = 1'b0;
              end else begin
                rom_addr_d = '0;
                state_d    = IDLE;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ptr_q      <= 2'd0;
      for (int i = 0; i < SD; i++) stk_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      stk_q      <= stk_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign ucode_busy = (state_q == RUN);
  assign ucode_done = done_q;
  assign stk_err    = err_q;

endmodule

// File: tb/tb_ucode_seq.sv
// Directed bench for ucode_seq: a queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_ucode_seq;

  localparam logic [2:0] S_INC = 3'd0, S_JMP = 3'd1, S_MWAY = 3'd2,
                         S_CALL = 3'd3, S_RET = 3'd4, S_END = 3'd5;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       start = 1'b0;
  logic [8:0] entry_addr = '0;
  logic       hold = 1'b0;
  logic [2:0] u_seq = S_INC;
  logic [8:0] u_jaddr = '0;
  logic       br_bit1 = 1'b0;
  logic       br_bit0 = 1'b0;
  logic [8:0] rom_addr;
  logic       ucode_busy;
  logic       ucode_done;
  logic       stk_err;

  int checks = 0;
  int errors = 0;

  int m_addr;
  bit m_busy, m_done, m_err;
  int m_stk[$];

  ucode_seq dut (
    .clk(clk), .reset_l(reset_l), .start(start), .entry_addr(entry_addr),
    .hold(hold), .u_seq(u_seq), .u_jaddr(u_jaddr), .br_bit1(br_bit1),
    .br_bit0(br_bit0), .rom_addr(rom_addr), .ucode_busy(ucode_busy),
    .ucode_done(ucode_done), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the sequencer must do with the inputs seen at each edge.
  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      m_addr = 0; m_busy = 0; m_done = 0; m_err = 0;
      m_stk.delete();
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_addr = entry_addr; m_err = 0; m_busy = 1;
          m_stk.delete();
        end
      end else if (!hold) begin
        if (u_seq == S_JMP) m_addr = u_jaddr;
        else if (u_seq == S_MWAY) m_addr = (u_jaddr / 4) * 4 + br_bit1 * 2 + br_bit0;
        else if (u_seq == S_CALL) begin
          if (m_stk.size() < 2) m_stk.push_back((m_addr + 1) % 512);
          else m_err = 1;
          m_addr = u_jaddr;
        end else if (u_seq == S_RET) begin
          if (m_stk.size() > 0) m_addr = m_stk.pop_back();
          else begin m_err = 1; m_addr = (m_addr + 1) % 512; end
        end else if (u_seq == S_END) begin
          m_done = 1;
          m_stk.delete();
          if (start) begin m_addr = entry_addr; m_err = 0; end
          else begin m_addr = 0; m_busy = 0; end
        end else m_addr = (m_addr + 1) % 512;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_l) begin
      chk("model_addr", rom_addr, m_addr);
      chk("model_busy", ucode_busy, m_busy);
      chk("model_done", ucode_done, m_done);
      chk("model_err", stk_err, m_err);
    end
  end

  // Present one word for one clock edge, then return just after the next falling edge.
  task automatic w(input logic [2:0] seq, input int ja, input logic [1:0] br,
                   input logic st, input int ea, input logic hd);
    u_seq = seq; u_jaddr = 9'(ja); br_bit1 = br[1]; br_bit0 = br[0];
    start = st; entry_addr = 9'(ea); hold = hd;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic ex(input string name, input int addr, input bit busy,
                    input bit done, input bit err);
    chk({name, "_addr"}, rom_addr, addr);
    chk({name, "_busy"}, ucode_busy, busy);
    chk({name, "_done"}, ucode_done, done);
    chk({name, "_err"}, stk_err, err);
    chk({name, "_maddr"}, m_addr, addr);
  endtask

  initial begin
    #12;
    ex("reset", 'h000, 0, 0, 0);
    reset_l = 1'b1;
    @(negedge clk); #1;

    // 1: entry, three INCs, END
    w(S_INC, 0, 2'b00, 1, 'h040, 0);  ex("t1_start", 'h040, 1, 0, 0);
    w(S_INC, 0, 2'b00, 0, 0, 0);
    w(S_INC, 0, 2'b00, 0, 0, 0);
    w(S_INC, 0, 2'b00, 0, 0, 0);      ex("t1_inc3", 'h043, 1, 0, 0);
    w(S_END, 0, 2'b00, 0, 0, 0);      ex("t1_end", 'h000, 0, 1, 0);
    w(S_INC, 0, 2'b00, 0, 0, 0);      ex("t1_idle", 'h000, 0, 0, 0);

    // 2: wrap and multi-way branch
    w(S_INC, 0, 2'b00, 1, 'h1FF, 0);  ex("t2_start", 'h1FF, 1, 0, 0);
    w(S_INC, 0, 2'b00, 0, 0, 0);      ex("t2_wrap", 'h000, 1, 0, 0);
    w(S_MWAY, 'h12C, 2'b10, 0, 0, 0); ex("t2_mway10", 'h12E, 1, 0, 0);
    w(S_MWAY, 'h12C, 2'b01, 0, 0, 0); ex("t2_mway01", 'h12D, 1, 0, 0);
    w(S_END, 0, 2'b00, 0, 0, 0);

    // 3: nested calls
    w(S_INC, 0, 2'b00, 1, 'h050, 0);
    w(S_CALL, 'h100, 2'b00, 0, 0, 0); ex("t3_call1", 'h100, 1, 0, 0);
    w(S_CALL, 'h180, 2'b00, 0, 0, 0); ex("t3_call2", 'h180, 1, 0, 0);
    w(S_RET, 0, 2'b00, 0, 0, 0);      ex("t3_ret1", 'h101, 1, 0, 0);
    w(S_RET, 0, 2'b00, 0, 0, 0);      ex("t3_ret2", 'h051, 1, 0, 0);

    // 4: overflow, underflow, cleared by next start
    w(S_CALL, 'h100, 2'b00, 0, 0, 0);
    w(S_CALL, 'h180, 2'b00, 0, 0, 0);
    w(S_CALL, 'h1C0, 2'b00, 1, 'h033, 0); ex("t4_ovf", 'h1C0, 1, 0, 1);
    w(S_RET, 0, 2'b00, 0, 0, 0);      ex("t4_ret1", 'h101, 1, 0, 1);
    w(S_RET, 0, 2'b00, 0, 0, 0);      ex("t4_ret2", 'h052, 1, 0, 1);
    w(S_JMP, 'h0A0, 2'b00, 0, 0, 0);
    w(S_INC, 0, 2'b00, 1, 'h00F, 0);  ex("t4_ignstart", 'h0A1, 1, 0, 1);
    w(S_JMP, 'h0A0, 2'b00, 0, 0, 0);
    w(S_RET, 0, 2'b00, 0, 0, 0);      ex("t4_unf", 'h0A1, 1, 0, 1);
    w(S_END, 0, 2'b00, 0, 0, 0);      ex("t4_end", 'h000, 0, 1, 1);
    w(S_INC, 0, 2'b00, 1, 'h010, 0);  ex("t4_clr", 'h010, 1, 0, 0);

    // 5: hold freezes everything, including a pending END
    w(S_CALL, 'h020, 2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++) w(S_RET, 0, 2'b00, 0, 0, 1);
    ex("t5_holdret", 'h020, 1, 0, 0);
    w(S_RET, 0, 2'b00, 0, 0, 0);      ex("t5_ret", 'h011, 1, 0, 0);
    for (int i = 0; i < 3; i++) w(S_JMP, 'h077, 2'b00, 0, 0, 1);
    ex("t5_holdjmp", 'h011, 1, 0, 0);
    w(S_JMP, 'h077, 2'b00, 0, 0, 0);  ex("t5_jmp", 'h077, 1, 0, 0);
    for (int i = 0; i < 3; i++) w(S_END, 0, 2'b00, 0, 0, 1);
    ex("t5_holdend", 'h077, 1, 0, 0);
    w(S_END, 0, 2'b00, 0, 0, 0);      ex("t5_end", 'h000, 0, 1, 0);

    // 6: back-to-back END/start, then reset mid-run
    w(S_INC, 0, 2'b00, 1, 'h0B0, 0);
    w(S_END, 0, 2'b00, 1, 'h0C8, 0);  ex("t6_b2b", 'h0C8, 1, 1, 0);
    w(S_CALL, 'h0D0, 2'b00, 0, 0, 0); ex("t6_call", 'h0D0, 1, 0, 0);
    reset_l = 1'b0;
    #1;
    ex("t6_rst", 'h000, 0, 0, 0);
    @(negedge clk); #1;
    reset_l = 1'b1;
    w(S_INC, 0, 2'b00, 1, 'h0E0, 0);
    w(S_RET, 0, 2'b00, 0, 0, 0);      ex("t6_unf", 'h0E1, 1, 0, 1);
    w(S_END, 0, 2'b00, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucode_seq.md
Name: ucode_seq

Overview:
- Microcode address sequencer for the IU microcode engine.
- Holds the registered 9-bit microcode ROM address and computes the next address from the current word's sequencing field.
- Next-address sources: increment, direct jump, multi-way branch (using bit1/bit0 from the branch-select logic), call and return.
- Maintains a 2-entry return stack and start/busy/done handshakes toward the IU decode pipe.

Parameters:
- AW, 9, microcode address width.
- SD, 2, return stack depth (fixed at 2; no other value is supported).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset_l  input  1  asynchronous active-low reset.
- start  input  1  request to enter microcode at entry_addr. Sampled only in IDLE, or in RUN on an END word with hold=0.
- entry_addr  input  9  microcode entry point for the instruction being started.
- hold  input  1  pipeline stall. When 1, all state is frozen.
- u_seq  input  3  sequencing field of the current ROM word (the ROM output for rom_addr, same cycle). Encoding:
  - 000 INC
  - 001 JMP
  - 010 MWAY
  - 011 CALL
  - 100 RET
  - 101 END
  - 110, 111 reserved; treated as INC
- u_jaddr  input  9  jump/branch/call target field of the current word.
- br_bit1  input  1  multi-way branch select, high bit.
- br_bit0  input  1  multi-way branch select, low bit.
- rom_addr  output  9  registered microcode ROM address.
- ucode_busy  output  1  1 while in RUN.
- ucode_done  output  1  one-cycle registered pulse after an END word retires.
- stk_err  output  1  sticky stack overflow/underflow flag; cleared on an accepted start.

Behaviour:

Reset (reset_l=0, asynchronous, any time including mid-sequence):
- rom_addr=0, ucode_busy=0, ucode_done=0, stk_err=0.
- Stack pointer=0, stack entries=0, state=IDLE.

States: IDLE, RUN. ucode_busy = (state==RUN).

ucode_done:
- Defaults to 0 every cycle.
- Set to 1 for exactly one cycle following the edge on which an END is taken.

IDLE:
- start=1 -> rom_addr<=entry_addr, stk_err<=0, stack pointer<=0, state<=RUN.
- start=0 -> remain in IDLE, rom_addr held.
- hold is ignored in IDLE.

RUN, hold=1:
- No register changes, including stack and stk_err.
- A pending END is not taken, so no done pulse.

RUN, hold=0, next address by u_seq:
- INC: rom_addr+1, modulo 512 (9'h1FF wraps to 9'h000).
- JMP: u_jaddr.
- MWAY: {u_jaddr[8:2], br_bit1, br_bit0}.
- CALL:
  - If pointer<2: push rom_addr+1 (mod 512), pointer+1, next=u_jaddr.
  - If pointer==2 (full): no push, stk_err<=1, next=u_jaddr.
- RET:
  - If pointer>0: pop top entry, pointer-1, next=popped value.
  - If pointer==0 (empty): stk_err<=1, next=rom_addr+1.
- END:
  - ucode_done<=1.
  - If start=1: rom_addr<=entry_addr, stk_err<=0, pointer<=0, stay in RUN (back-to-back, no bubble).
  - Else: rom_addr<=0, pointer<=0, state<=IDLE.

Other rules:
- start in RUN on any word other than END is ignored and is not queued.
- Stack is LIFO. Entry 0 is the bottom. Pop returns entry[pointer-1].
- Latency: address change is visible one clock after the word is presented. No combinational path from inputs to outputs.
- Coverage: all case statements are fully specified with no unreachable default arm.

Test Plan:
1. Reset, then start=1 with entry_addr=9'h040 in IDLE -> next cycle rom_addr=040, busy=1. Three INC words -> 041, 042, 043. END -> done=1 for one cycle, busy=0, rom_addr=000.
2. Wrap: rom_addr=1FF, INC -> 000. MWAY with u_jaddr=9'h12C, {bit1,bit0}=2'b10 -> rom_addr=12E. Same with 2'b01 -> 12D.
3. Nested calls: at 050 CALL 100, at 100 CALL 180, at 180 RET -> 101, at 101 RET -> 051. stk_err stays 0.
4. Overflow/underflow:
   - Third CALL while stack full -> jumps to target, stk_err=1, stack contents unchanged.
   - RET with empty stack at 0A0 -> 0A1, stk_err=1.
   - Next accepted start clears stk_err.
5. hold=1 asserted for 3 cycles on a JMP word, then on an END word -> rom_addr, stack and stk_err frozen; no done pulse until hold drops; jump/END taken on the first hold=0 cycle.
6. Back-to-back and reset:
   - END with start=1, entry_addr=0C8 -> done pulse, busy stays 1, rom_addr=0C8.
   - reset_l low mid-RUN with 1 stack entry -> immediately rom_addr=0, busy=0; a subsequent RET underflows (stk_err=1).
